// File: rtl/cache_axi_rr_arbiter.sv
// cache_axi_rr_arbiter
//   Line-fill / write-back adapter between CLIENTS private caches and one AXI4
//   master port with an ACE-lite snoop channel. Client requests are arbitrated
//   round-robin. Each granted request becomes one INCR burst of BEATS beats:
//   a read fill or a write-back. The whole line (reads) or a write completion
//   is returned to the requester together with the OR of all AXI error responses.
//   MakeInvalid snoops (acsnoop 0xd) are turned into a one-cycle invalidate pulse.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_*                 per-client request: valid/write/addr/wdata in, one-hot ready out
//   resp_*                one-hot completion, line data, error flag
//   inval_valid/addr      invalidate broadcast
//   m_axi_ar/r/aw/w/b     AXI4 master channels
//   m_axi_ac*             snoop address channel
module cache_axi_rr_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int BEATS      = 8,
  parameter int CLIENTS    = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [CLIENTS-1:0]                        req_valid,
  input  logic [CLIENTS-1:0]                        req_write,
  input  logic [CLIENTS-1:0][ADDR_WIDTH-1:0]        req_addr,
  input  logic [CLIENTS-1:0][DATA_WIDTH*BEATS-1:0]  req_wdata,
  output logic [CLIENTS-1:0]                        req_ready,
  output logic [CLIENTS-1:0]                        resp_valid,
  input  logic [CLIENTS-1:0]                        resp_ready,
  output logic [DATA_WIDTH*BEATS-1:0]               resp_data,
  output logic                                      resp_err,
  output logic                                      inval_valid,
  output logic [ADDR_WIDTH-1:0]                     inval_addr,
  output logic [ADDR_WIDTH-1:0]                     m_axi_araddr,
  output logic [7:0]                                m_axi_arlen,
  output logic [2:0]                                m_axi_arsize,
  output logic [1:0]                                m_axi_arburst,
  output logic                                      m_axi_arvalid,
  input  logic                                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]                     m_axi_rdata,
  input  logic [1:0]                                m_axi_rresp,
  input  logic                                      m_axi_rlast,
  input  logic                                      m_axi_rvalid,
  output logic                                      m_axi_rready,
  output logic [ADDR_WIDTH-1:0]                     m_axi_awaddr,
  output logic [7:0]                                m_axi_awlen,
  output logic [2:0]                                m_axi_awsize,
  output logic [1:0]                                m_axi_awburst,
  output logic                                      m_axi_awvalid,
  input  logic                                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]                     m_axi_wdata,
  output logic                                      m_axi_wlast,
  output logic                                      m_axi_wvalid,
  input  logic                                      m_axi_wready,
  input  logic [1:0]                                m_axi_bresp,
  input  logic                                      m_axi_bvalid,
  output logic                                      m_axi_bready,
  input  logic                                      m_axi_acvalid,
  output logic                                      m_axi_acready,
  input  logic [ADDR_WIDTH-1:0]                     m_axi_acaddr,
  input  logic [3:0]                                m_axi_acsnoop
);

  localparam int LINE = DATA_WIDTH * BEATS;
  localparam int OFF  = $clog2(LINE / 8);
  localparam int BW   = $clog2(BEATS);
  localparam int IDW  = $clog2(CLIENTS);
  localparam int SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP} state_t;

  state_t                             state, state_n;
  logic [IDW-1:0]                     rr_ptr, id, grant_id, cand;
  logic [CLIENTS-1:0]                 grant_oh;
  logic                               found, accept;
  logic [ADDR_WIDTH-1:0]              addr;
  logic                               err;
  logic [BW-1:0]                      beat;
  logic [BEATS-1:0][DATA_WIDTH-1:0]   line_buf;
  logic                               snp_busy, ac_fire;

  // Round-robin search: first valid client at or after rr_ptr, wrapping.
  always_comb begin
    grant_oh = '0;
    grant_id = '0;
    cand     = '0;
    found    = 1'b0;
    for (int i = 0; i < CLIENTS; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % CLIENTS);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
    if (found) grant_oh[grant_id] = 1'b1;
  end

  assign req_ready = (state == S_IDLE && !reset) ? grant_oh : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_n       = state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    resp_valid    = '0;
    case (state)
      S_IDLE: if (accept) state_n = req_write[grant_id] ? S_AW : S_AR;
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_n = S_R;
      end
      S_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) state_n = S_RESP;
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_n = S_W;
      end
      S_W: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && m_axi_wlast) state_n = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_n = S_RESP;
      end
      S_RESP: begin
        resp_valid[id] = 1'b1;
        if (resp_ready[id]) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      id       <= '0;
      addr     <= '0;
      err      <= 1'b0;
      beat     <= '0;
      line_buf <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (accept) begin
          id     <= grant_id;
          addr   <= req_addr[grant_id] & LINE_MASK;
          rr_ptr <= (grant_id == IDW'(CLIENTS-1)) ? '0 : grant_id + IDW'(1);
          err    <= 1'b0;
          if (req_write[grant_id]) line_buf <= req_wdata[grant_id];
        end
        S_R: if (m_axi_rvalid) begin
          line_buf[beat] <= m_axi_rdata;
          beat           <= beat + BW'(1);
          if (m_axi_rresp != 2'b00) err <= 1'b1;
          if (m_axi_rlast) begin
            beat <= '0;
            // A short burst leaves stale beats in the line; flag it.
            if (beat != BW'(BEATS-1)) err <= 1'b1;
          end
        end
        S_W: if (m_axi_wready) beat <= m_axi_wlast ? '0 : beat + BW'(1);
        S_B: if (m_axi_bvalid && m_axi_bresp != 2'b00) err <= 1'b1;
        default: ;
      endcase
    end
  end

  // Snoop path runs beside the FSM. One cycle of back-pressure after each
  // accepted snoop gives the invalidate pulse its slot.
  assign m_axi_acready = !snp_busy && !reset;
  assign ac_fire       = m_axi_acvalid && m_axi_acready;

  always_ff @(posedge clk) begin
    if (reset) begin
      snp_busy    <= 1'b0;
      inval_valid <= 1'b0;
      inval_addr  <= '0;
    end else begin
      snp_busy    <= ac_fire;
      inval_valid <= ac_fire && (m_axi_acsnoop == 4'hd);
      if (ac_fire) inval_addr <= m_axi_acaddr;
    end
  end

  assign m_axi_araddr  = addr;
  assign m_axi_awaddr  = addr;
  assign m_axi_arlen   = 8'(BEATS-1);
  assign m_axi_awlen   = 8'(BEATS-1);
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = line_buf[beat];
  assign m_axi_wlast   = (state == S_W) && (beat == BW'(BEATS-1));
  assign resp_data     = line_buf;
  assign resp_err      = err;

endmodule

// File: tb/tb_cache_axi_rr_arbiter.sv
// Randomized bench for cache_axi_rr_arbiter: random client requests, a random-
// latency AXI slave, random snoops and random resp_ready. A line-level model
// predicts grants and completions; the slave checks burst fields and write data.
// Address bit 20 asks the slave for an error response (beat addr[18:16] or bresp);
// bit 21 asks for a short read burst of addr[25:23]+1 beats.
module tb_cache_axi_rr_arbiter;
  localparam int DW = 64, AW = 64, NB = 8, NC = 4, LINE = DW * NB;

  logic clk, reset;
  logic [NC-1:0] req_valid, req_write, req_ready, resp_valid, resp_ready;
  logic [NC-1:0][AW-1:0] req_addr;
  logic [NC-1:0][LINE-1:0] req_wdata;
  logic [LINE-1:0] resp_data;
  logic resp_err, inval_valid;
  logic [AW-1:0] inval_addr, araddr, awaddr, acaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready, acvalid, acready;
  logic [DW-1:0] rdata, wdata;
  logic [3:0] acsnoop;

  cache_axi_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BEATS(NB), .CLIENTS(NC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .inval_valid(inval_valid), .inval_addr(inval_addr),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .m_axi_acvalid(acvalid), .m_axi_acready(acready),
    .m_axi_acaddr(acaddr), .m_axi_acsnoop(acsnoop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int id; bit wr; bit err; logic [LINE-1:0] data; } exp_t;
  exp_t exp_q[$];

  int checks = 0, passes = 0, ndone = 0;
  int rr_m = 0, wr_b = 0, dir_c = -1;
  bit busy = 0, chk_en = 0, snp_en = 0, gen_en = 0, dir_wr;
  logic [AW-1:0] cur_addr, dir_addr;
  logic [LINE-1:0] cur_wdata, line_m, dir_data;
  logic [NC-1:0] acc;

  task automatic chk(input bit ok, input string nm, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] rd_beat(input logic [AW-1:0] a, input int k);
    return {a[31:0] ^ 32'hA5A5_0000, 24'h0, 8'(8'hA0 + k)};
  endfunction
  function automatic int lenof(input logic [AW-1:0] a);
    return a[21] ? int'(a[25:23]) + 1 : NB;
  endfunction
  function automatic int errbeat(input logic [AW-1:0] a);
    return int'(a[18:16]);
  endfunction

  // Arbitration monitor: expected grant, and expected completion at acceptance.
  initial begin : arb_mon
    logic [NC-1:0] er, hs;
    int c, gid, len;
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (chk_en && !reset) begin
        er = '0;
        if (!busy)
          for (int i = 0; i < NC; i++) begin
            c = (rr_m + i) % NC;
            if (er == 0 && req_valid[c]) er[c] = 1'b1;
          end
        chk(req_ready == er, "grant", LINE'(req_ready), LINE'(er));
        hs = req_valid & req_ready;
        if (hs != 0) begin
          gid = 0;
          for (int i = 0; i < NC; i++) if (hs[i]) gid = i;
          rr_m = (gid + 1) % NC;
          busy = 1;
          cur_addr = req_addr[gid] & ~64'h3f;
          cur_wdata = req_wdata[gid];
          e.id = gid;
          e.wr = req_write[gid];
          if (e.wr) begin
            line_m = cur_wdata;
            e.err = cur_addr[20];
          end else begin
            len = lenof(cur_addr);
            for (int k = 0; k < len; k++) line_m[k*DW +: DW] = rd_beat(cur_addr, k);
            e.err = (cur_addr[20] && errbeat(cur_addr) < len) || (len < NB);
          end
          e.data = line_m;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Completion monitor.
  initial begin : resp_mon
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (chk_en && !reset && resp_valid != 0) begin
        if (exp_q.size() == 0) chk(1'b0, "resp_unexpected", LINE'(resp_valid), '0);
        else begin
          e = exp_q[0];
          chk(resp_valid == NC'(1 << e.id), "resp_id", LINE'(resp_valid), LINE'(1 << e.id));
          chk(resp_err == e.err, "resp_err", LINE'(resp_err), LINE'(e.err));
          if (!e.wr) chk(resp_data == e.data, "resp_data", resp_data, e.data);
          if (resp_ready[e.id]) begin
            void'(exp_q.pop_front());
            busy = 0;
            ndone++;
          end
        end
      end
    end
  end

  initial begin : rdy_drv
    resp_ready = '0;
    forever begin @(negedge clk); resp_ready = NC'($urandom); end
  end

  // AXI slave with random stalls.
  initial begin : slave
    bit rd_act, wr_act, b_pend;
    logic [AW-1:0] rd_a, wr_a;
    int rd_b;
    rd_act = 0; wr_act = 0; b_pend = 0; rd_b = 0; rd_a = '0; wr_a = '0;
    arready = 0; awready = 0; rvalid = 0; wready = 0; bvalid = 0;
    rdata = '0; rresp = '0; rlast = 0; bresp = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_act = 0; wr_act = 0; b_pend = 0; wr_b = 0;
        arready = 0; awready = 0; rvalid = 0; wready = 0; bvalid = 0;
      end else begin
        arready = 1'($urandom % 2);
        awready = 1'($urandom % 2);
        rvalid  = rd_act && ($urandom % 4 != 0);
        rdata   = rd_beat(rd_a, rd_b);
        rresp   = (rd_a[20] && rd_b == errbeat(rd_a)) ? 2'd2 : 2'd0;
        rlast   = (rd_b == lenof(rd_a) - 1);
        wready  = wr_act && ($urandom % 3 != 0);
        bvalid  = b_pend && ($urandom % 2 != 0);
        bresp   = wr_a[20] ? 2'd2 : 2'd0;
        #2;
        if (arvalid && arready) begin
          chk(araddr == cur_addr, "araddr", LINE'(araddr), LINE'(cur_addr));
          chk(arlen == 8'd7 && arsize == 3'd3 && arburst == 2'd1, "ar_fields",
              LINE'({arlen, arsize, arburst}), LINE'({8'd7, 3'd3, 2'd1}));
          rd_act = 1; rd_a = araddr; rd_b = 0;
        end else if (rvalid && rready) begin
          if (rlast) rd_act = 0;
          rd_b++;
        end
        if (awvalid && awready) begin
          chk(awaddr == cur_addr, "awaddr", LINE'(awaddr), LINE'(cur_addr));
          chk(awlen == 8'd7 && awsize == 3'd3 && awburst == 2'd1, "aw_fields",
              LINE'({awlen, awsize, awburst}), LINE'({8'd7, 3'd3, 2'd1}));
          wr_act = 1; wr_a = awaddr; wr_b = 0;
        end else if (wvalid && wready) begin
          chk(wdata == cur_wdata[wr_b*DW +: DW], "wdata", LINE'(wdata), LINE'(cur_wdata[wr_b*DW +: DW]));
          chk(wlast == (wr_b == NB - 1), "wlast", LINE'(wlast), LINE'(wr_b == NB - 1));
          if (wr_b == NB - 1) begin wr_act = 0; b_pend = 1; end
          wr_b++;
        end
        if (bvalid && bready) b_pend = 0;
      end
    end
  end

  // Snoop source and invalidate checker.
  initial begin : snoop
    bit pf, pi;
    logic [AW-1:0] pa;
    int r;
    pf = 0; pi = 0; pa = '0;
    acvalid = 0; acaddr = '0; acsnoop = '0;
    forever begin
      @(negedge clk);
      if (reset || !snp_en) begin
        acvalid = 0; pf = 0;
      end else begin
        if (pf) acvalid = 0;
        if (!acvalid && $urandom % 6 == 0) begin
          acvalid = 1;
          r = $urandom % 3;
          acsnoop = (r == 0) ? 4'hd : (r == 1) ? 4'h0 : 4'h7;
          acaddr = {$urandom, $urandom};
        end
        #2;
        chk(inval_valid == (pf && pi), "inval_valid", LINE'(inval_valid), LINE'(pf && pi));
        if (pf && pi) chk(inval_addr == pa, "inval_addr", LINE'(inval_addr), LINE'(pa));
        if (pf) chk(acready == 1'b0, "acready_drop", LINE'(acready), '0);
        pf = acvalid && acready;
        if (pf) begin pi = (acsnoop == 4'hd); pa = acaddr; end
      end
    end
  end

  // One request cycle: retire accepted requests, inject directed/random ones.
  task automatic step();
    logic [AW-1:0] a;
    @(negedge clk);
    req_valid &= ~acc;
    if (dir_c >= 0) begin
      req_valid[dir_c] = 1'b1; req_write[dir_c] = dir_wr;
      req_addr[dir_c] = dir_addr; req_wdata[dir_c] = dir_data;
      dir_c = -1;
    end
    if (gen_en)
      for (int c = 0; c < NC; c++)
        if (!req_valid[c] && $urandom % 3 == 0) begin
          a = {$urandom, $urandom};
          a[20] = ($urandom % 5 == 0);
          a[21] = ($urandom % 6 == 0);
          req_valid[c] = 1'b1;
          req_write[c] = 1'($urandom % 2);
          req_addr[c] = a;
          for (int k = 0; k < NB; k++) req_wdata[c][k*DW +: DW] = {$urandom, $urandom};
        end
    #2;
    acc = req_valid & req_ready;
  endtask

  task automatic issue(input int c, input bit wr, input logic [AW-1:0] a, input logic [LINE-1:0] d);
    int n0, t;
    n0 = ndone; t = 0;
    dir_c = c; dir_wr = wr; dir_addr = a; dir_data = d;
    while (ndone == n0 && t < 300) begin step(); t++; end
    if (ndone == n0) chk(1'b0, "issue_timeout", LINE'(t), '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({req_ready, resp_valid} == '0, {tag, "_req_resp"}, LINE'({req_ready, resp_valid}), '0);
    chk({arvalid, rready, awvalid, wvalid, wlast, bready} == '0, {tag, "_axi_valids"},
        LINE'({arvalid, rready, awvalid, wvalid, wlast, bready}), '0);
    chk({inval_valid, resp_err, acready} == '0, {tag, "_misc"}, LINE'({inval_valid, resp_err, acready}), '0);
    chk(resp_data == '0, {tag, "_line"}, resp_data, '0);
    chk(araddr == '0, {tag, "_addr"}, LINE'(araddr), '0);
  endtask

  initial begin : main
    logic [LINE-1:0] d;
    int t;
    reset = 1; acc = '0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    line_m = '0; cur_addr = '0; cur_wdata = '0; dir_addr = '0; dir_data = '0; dir_wr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 0; chk_en = 1; snp_en = 1;

    // Clean read, read with SLVERR on beat 3, clean write of 0x10..0x17.
    issue(2, 1'b0, 64'h1238, '0);
    issue(2, 1'b0, 64'h1238 | (64'd1 << 20) | (64'd3 << 16), '0);
    for (int k = 0; k < NB; k++) d[k*DW +: DW] = 64'(8'h10 + k);
    issue(1, 1'b1, 64'h2000, d);

    gen_en = 1;
    repeat (3000) step();
    gen_en = 0;
    t = 0;
    while ((req_valid != 0 || busy || exp_q.size() != 0) && t < 3000) begin step(); t++; end
    if (t >= 3000) chk(1'b0, "drain_timeout", LINE'(exp_q.size()), '0);

    // Reset while the write burst sits at beat 3.
    snp_en = 0;
    repeat (3) step();
    for (int k = 0; k < NB; k++) d[k*DW +: DW] = {$urandom, $urandom};
    dir_c = 1; dir_wr = 1; dir_addr = 64'h3000; dir_data = d;
    t = 0;
    do begin step(); #1; t++; end while (!(wvalid && wr_b == 3) && t < 300);
    if (t >= 300) chk(1'b0, "w_beat3_timeout", LINE'(wr_b), LINE'(3));
    reset = 1;
    req_valid = '0; acc = '0;
    @(negedge clk); #1;
    check_reset_outputs("midreset");
    exp_q.delete(); busy = 0; rr_m = 0; line_m = '0;
    @(negedge clk);
    reset = 0;
    snp_en = 1;
    issue(0, 1'b0, 64'h5040, '0);
    repeat (5) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
